mont_convert_in: RTL and testbench

//  Converts an ordinary residue a (0 <= a < n) into Montgomery form a*R mod n, with R = 2^LEN.
//  It is the entry-side counterpart to Montgomery reduction: mont_redc maps values back out of the domain.

---
 rtl/mont_pkg.sv | 15 +
 rtl/mont_dbl_mod.sv | 22 ++
 rtl/mont_convert_in.sv | 109 ++++++++++
 tb/tb_mont_convert_in.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared state encoding and sizing helpers for the sequential mont blocks
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mont_state_e;

  // Counter width able to hold 0..len inclusive.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/mont_dbl_mod.sv
// rtl/mont_dbl_mod.sv - combinational modular doubling, q = 2*r mod n for r < n
module mont_dbl_mod #(
  parameter int LEN = 2048
) (
  input  logic [LEN-1:0] r,
  input  logic [LEN-1:0] n,
  output logic [LEN-1:0] q
);

  logic [LEN:0] t;
  logic [LEN:0] n_ext;
  logic         ge;

  // The doubled value needs one extra bit; since r < n the result after at most one subtract is < n.
  always_comb begin
    t     = {r, 1'b0};
    n_ext = {1'b0, n};
    ge    = (t >= n_ext);
    q     = ge ? LEN'(t - n_ext) : t[LEN-1:0];
  end

endmodule

// File: rtl/mont_convert_in.sv
// rtl/mont_convert_in.sv - bit-serial a*2^LEN mod n; MONT_CONVERT_IN_CHECK_EN adds the err port and operand checks
module mont_convert_in
  import mont_pkg::*;
#(
  parameter int LEN = 2048
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] res
`ifdef MONT_CONVERT_IN_CHECK_EN
  ,
  output logic           err
`endif
);

  localparam int CW = cnt_w(LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

  mont_state_e    state;
  logic [CW-1:0]  cnt;
  logic [LEN-1:0] r;
  logic [LEN-1:0] n_q;
  logic [LEN-1:0] r_dbl;

  mont_dbl_mod #(
    .LEN(LEN)
  ) u_dbl (
    .r(r),
    .n(n_q),
    .q(r_dbl)
  );

  assign res = r;

`ifdef MONT_CONVERT_IN_CHECK_EN
  logic illegal;
  assign illegal = (n == '0) || !n[0] || (a >= n);
`endif

  // in_ready / out_valid are registered copies of the state decode, held low through reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      r         <= '0;
      n_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
`ifdef MONT_CONVERT_IN_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            n_q      <= n;
            cnt      <= '0;
            in_ready <= 1'b0;
`ifdef MONT_CONVERT_IN_CHECK_EN
            if (illegal) begin
              r         <= '0;
              err       <= 1'b1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              r     <= a;
              state <= ST_RUN;
            end
`else
            r     <= a;
            state <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          r   <= r_dbl;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef MONT_CONVERT_IN_CHECK_EN
            err       <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mont_convert_in.sv
// tb/tb_mont_convert_in.sv - directed and randomized checks of mont_convert_in at LEN=8
module tb_mont_convert_in;

  localparam int L = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [L-1:0] a;
  logic [L-1:0] n;
  logic         out_valid;
  logic         out_ready;
  logic [L-1:0] res;
`ifdef MONT_CONVERT_IN_CHECK_EN
  logic         err;
`endif

  int checks   = 0;
  int failures = 0;
  logic got_err;

  mont_convert_in #(
    .LEN(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .n(n),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res(res)
`ifdef MONT_CONVERT_IN_CHECK_EN
    ,
    .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a * 2^L mod n, plain integer arithmetic.
  function automatic int ref_conv(input int av, input int nv);
    return (av * (1 << L)) % nv;
  endfunction

  // Inverse of 2^L mod n by search; used to map a result back out of the domain.
  function automatic int inv_r(input int nv);
    for (int x = 0; x < nv; x++)
      if (((1 << L) * x) % nv == 1) return x;
    return 0;
  endfunction

  // lat counts posedges with the accepting edge as number 1.
  task automatic convert(input logic [L-1:0] av, input logic [L-1:0] nv, input int bp,
                         output logic [L-1:0] got, output int lat);
    int waitc;
    logic [L-1:0] held;
    waitc = 0;
    while (!in_ready && waitc < 40) begin
      @(posedge clk);
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    a = av;
    n = nv;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = L'($urandom);
    n = L'($urandom);
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      in_valid = $urandom_range(0, 1) == 1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("out_valid_seen", 64'(out_valid), 64'd1);
    held = res;
`ifdef MONT_CONVERT_IN_CHECK_EN
    got_err = err;
`else
    got_err = 1'b0;
`endif
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_res_stable", 64'(res), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    got = res;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_in_ready", 64'(in_ready), 64'd1);
    chk("hs_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [L-1:0] got;
    int lat;
    int nv, av, ex;
    logic [L-1:0] dir_a [3];
    logic [L-1:0] dir_e [3];

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    n = '0;
    got_err = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    convert(8'd1, 8'd13, 0, got, lat);
    chk("n13_a1_res", 64'(got), 64'd9);
    chk("n13_a1_latency", 64'(lat), 64'(L + 1));

    dir_a[0] = 8'd0;  dir_e[0] = 8'd0;
    dir_a[1] = 8'd5;  dir_e[1] = 8'd6;
    dir_a[2] = 8'd12; dir_e[2] = 8'd4;
    for (int i = 0; i < 3; i++) begin
      convert(dir_a[i], 8'd13, 0, got, lat);
      chk("n13_dir_res", 64'(got), 64'(dir_e[i]));
    end
    convert(8'd250, 8'd251, 0, got, lat);
    chk("n251_a250_res", 64'(got), 64'd246);

    convert(8'd7, 8'd13, 20, got, lat);
    chk("bp_res", 64'(got), 64'(ref_conv(7, 13)));

    // Abort after three doublings.
    a = 8'd1;
    n = 8'd13;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid_rel", 64'(out_valid), 64'd0);
    convert(8'd1, 8'd13, 0, got, lat);
    chk("midrst_next_res", 64'(got), 64'd9);

    for (int k = 0; k < 200; k++) begin
      nv = $urandom_range(1, 127) * 2 + 1;
      av = $urandom_range(0, nv - 1);
      ex = ref_conv(av, nv);
      convert(L'(av), L'(nv), $urandom_range(0, 3), got, lat);
      chk("rand_res", 64'(got), 64'(ex));
      chk("rand_latency", 64'(lat), 64'(L + 1));
      chk("rand_roundtrip", 64'((int'(got) * inv_r(nv)) % nv), 64'(av));
      chk("rand_err", 64'(got_err), 64'd0);
    end

`ifdef MONT_CONVERT_IN_CHECK_EN
    convert(8'd1, 8'd12, 0, got, lat);
    chk("chk_even_err", 64'(got_err), 64'd1);
    chk("chk_even_res", 64'(got), 64'd0);
    chk("chk_even_latency", 64'(lat), 64'd1);
    convert(8'd13, 8'd13, 0, got, lat);
    chk("chk_ge_err", 64'(got_err), 64'd1);
    convert(8'd3, 8'd0, 0, got, lat);
    chk("chk_zero_err", 64'(got_err), 64'd1);
    convert(8'd1, 8'd13, 0, got, lat);
    chk("chk_legal_err", 64'(got_err), 64'd0);
    chk("chk_legal_res", 64'(got), 64'd9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
